vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  Sequences the console's pixel-rate datapath: divides clk into a one-cycle pixel_tick enable,
//  then runs horizontal/vertical scan counters on that enable to produce hsync, vsync,
//  video_on and the current pixel coordinates. Sits between the board clock and the
//  game renderer/VGA pins; every pixel-rate block in the console qualifies its logic with
//  pixel_tick instead of using a derived clock.
// PARAMETERS
//  DIV        2    clk cycles per pixel (>=2); pixel_tick period
//  H_VISIBLE  640  visible pixels per line
//  H_FP       16   horizontal front porch (pixels)
//  H_SYNC     96   horizontal sync width (pixels)
//  H_BP       48   horizontal back porch (pixels)
//  V_VISIBLE  480  visible lines per frame
//  V_FP       10   vertical front porch (lines)
//  V_SYNC     2    vertical sync width (lines)
//  V_BP       33   vertical back porch (lines)
//  SYNC_POL   0    asserted level of hsync/vsync (0 = active-low)
//  CW         10   width of pixel_x/pixel_y and internal scan counters
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  en           in   1   run enable; low = timing held idle
//  pixel_tick   out  1   one-clk pulse every DIV clks while running
//  hsync        out  1   horizontal sync, level per SYNC_POL
//  vsync        out  1   vertical sync, level per SYNC_POL
//  video_on     out  1   1 while (pixel_x,pixel_y) lies in the visible area
//  pixel_x      out  CW  current horizontal count, 0..H_TOTAL-1
//  pixel_y      out  CW  current vertical count, 0..V_TOTAL-1
//  line_start   out  1   one-clk pulse coincident with the tick that moves pixel_x to 0
//  frame_start  out  1   one-clk pulse coincident with the tick that moves to (0,0)
// BEHAVIOUR
//  - H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525).
//  - Reset (async, rst_n=0): div_cnt=0, pixel_x=0, pixel_y=0, pixel_tick=0, line_start=0,
//    frame_start=0, video_on=0, hsync=vsync=~SYNC_POL. FSM -> IDLE.
//  - FSM: IDLE --en=1--> RUN; RUN --en=0--> IDLE (at next clk edge, any point in frame).
//    IDLE: div_cnt, pixel_x, pixel_y forced to 0; syncs deasserted; video_on=0; no pulses.
//  - RUN divider: div_cnt counts 0..DIV-1 and wraps; pixel_tick=1 for the single clk in
//    which div_cnt==DIV-1. First tick occurs DIV clks after entering RUN.
//  - Scan counters advance only on clk edges where pixel_tick=1:
//    pixel_x==H_TOTAL-1 -> pixel_x=0 and pixel_y increments (wraps V_TOTAL-1 -> 0);
//    otherwise pixel_x increments. Counters never exceed TOTAL-1.
//  - hsync, vsync, video_on are registered, decoded from the NEXT counter values, so they
//    change on the same clk edge as pixel_x/pixel_y and always match them (zero skew):
//    hsync asserted iff H_VISIBLE+H_FP <= pixel_x < H_VISIBLE+H_FP+H_SYNC (656..751);
//    vsync asserted iff V_VISIBLE+V_FP <= pixel_y < V_VISIBLE+V_FP+V_SYNC (490..491);
//    video_on=1 iff pixel_x<H_VISIBLE and pixel_y<V_VISIBLE.
//  - Leaving IDLE: the (0,0) outputs hold for DIV clks, then first tick moves to (1,0).
//    Therefore pixel (0,0) is visible immediately on entering RUN; video_on goes 1 one clk
//    after en is sampled high.
//  - line_start/frame_start: registered, high for exactly one clk after the edge where
//    counters wrap to x=0 / (0,0); frame_start implies line_start in the same cycle.
//  - en dropped mid-frame: next edge returns to IDLE state above; no partial pulse emitted.
//  - Reset mid-frame: all outputs take reset values immediately (asynchronous).
// TESTING
//  1 rst_n=0 then 1, en=1, DIV=2 -> pixel_tick every 2nd clk; pixel_x 0->1 at first tick.
//  2 Run one line -> hsync asserted for exactly 96 ticks (192 clks) at x=656..751; line
//    period 800 ticks = 1600 clks; line_start one clk at x wrap 799->0.
//  3 Run full frame -> vsync asserted for lines 490..491 only; frame_start period 840000
//    clks; video_on high for exactly 640*480=307200 ticks per frame.
//  4 Deassert en at x=300,y=200 -> next clk x=0,y=0, syncs inactive, video_on=0,
//    pixel_tick=0; re-assert -> restarts at (0,0) with no spurious frame_start.
//  5 Assert rst_n=0 asynchronously mid-hsync (x=700) -> hsync/vsync go inactive and
//    counters 0 before next clk edge.
//  6 DIV=4, SYNC_POL=1 -> tick every 4th clk; hsync high during x=656..751, low elsewhere.

Source files
------------

// File: rtl/vga_timing_if.sv
// Pixel-timing bundle between the timing controller and its consumers (renderer, VGA pins).
// Handshake: en is a level run request from the consumer; pixel_tick is a one-clk strobe, no back-pressure.
interface vga_timing_if #(
   parameter int CW = 10
);
   logic          en;
   logic          pixel_tick;
   logic          hsync;
   logic          vsync;
   logic          video_on;
   logic [CW-1:0] pixel_x;
   logic [CW-1:0] pixel_y;
   logic          line_start;
   logic          frame_start;
   logic          state_dbg;

   modport master (
      input  en,
      output pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
      output line_start, frame_start, state_dbg
   );

   modport slave (
      output en,
      input  pixel_tick, hsync, vsync, video_on, pixel_x, pixel_y,
      input  line_start, frame_start, state_dbg
   );
endinterface

// File: rtl/vga_timing_ctrl.sv
// VGA timing: clk divider producing pixel_tick, plus h/v scan counters with zero-skew registered decode.
// state_dbg reports the run state (1 = RUN).
module vga_timing_ctrl #(
   parameter int DIV       = 2,
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter bit SYNC_POL  = 1'b0,
   parameter int CW        = 10
) (
   input  logic         clk,
   input  logic         rst_n,
   vga_timing_if.master vga
);
   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam int DW      = (DIV > 2) ? $clog2(DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_VIS    = CW'(H_VISIBLE);
   localparam logic [CW-1:0] V_VIS    = CW'(V_VISIBLE);
   localparam logic [CW-1:0] HS_START = CW'(H_VISIBLE + H_FP);
   localparam logic [CW-1:0] HS_END   = CW'(H_VISIBLE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_START = CW'(V_VISIBLE + V_FP);
   localparam logic [CW-1:0] VS_END   = CW'(V_VISIBLE + V_FP + V_SYNC);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t        state;
   logic [DW-1:0] div_cnt, div_nxt;
   logic [CW-1:0] x, y, x_nxt, y_nxt;
   logic          tick, hs, vs, von, ls, fs;

   function automatic logic hs_of(input logic [CW-1:0] px);
      return (px >= HS_START && px < HS_END) ? SYNC_POL : ~SYNC_POL;
   endfunction

   function automatic logic vs_of(input logic [CW-1:0] py);
      return (py >= VS_START && py < VS_END) ? SYNC_POL : ~SYNC_POL;
   endfunction

   function automatic logic von_of(input logic [CW-1:0] px, input logic [CW-1:0] py);
      return (px < H_VIS) && (py < V_VIS);
   endfunction

   // Next scan position; the registered tick marks the edge on which counters move.
   always_comb begin
      div_nxt = (div_cnt == DIV_LAST) ? '0 : div_cnt + DW'(1);
      x_nxt   = x;
      y_nxt   = y;
      if (tick) begin
         if (x == H_LAST) begin
            x_nxt = '0;
            y_nxt = (y == V_LAST) ? '0 : y + CW'(1);
         end else begin
            x_nxt = x + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         div_cnt <= '0;
         x       <= '0;
         y       <= '0;
         tick    <= 1'b0;
         ls      <= 1'b0;
         fs      <= 1'b0;
         von     <= 1'b0;
         hs      <= ~SYNC_POL;
         vs      <= ~SYNC_POL;
      end else if (!vga.en) begin
         state   <= IDLE;
         div_cnt <= '0;
         x       <= '0;
         y       <= '0;
         tick    <= 1'b0;
         ls      <= 1'b0;
         fs      <= 1'b0;
         von     <= 1'b0;
         hs      <= ~SYNC_POL;
         vs      <= ~SYNC_POL;
      end else if (state == IDLE) begin
         // Entering RUN presents pixel (0,0) at once, without a frame_start pulse.
         state   <= RUN;
         div_cnt <= '0;
         x       <= '0;
         y       <= '0;
         tick    <= 1'b0;
         ls      <= 1'b0;
         fs      <= 1'b0;
         von     <= von_of('0, '0);
         hs      <= hs_of('0);
         vs      <= vs_of('0);
      end else begin
         div_cnt <= div_nxt;
         x       <= x_nxt;
         y       <= y_nxt;
         tick    <= (div_nxt == DIV_LAST);
         ls      <= tick && (x == H_LAST);
         fs      <= tick && (x == H_LAST) && (y == V_LAST);
         von     <= von_of(x_nxt, y_nxt);
         hs      <= hs_of(x_nxt);
         vs      <= vs_of(y_nxt);
      end
   end

   assign vga.pixel_tick  = tick;
   assign vga.hsync       = hs;
   assign vga.vsync       = vs;
   assign vga.video_on    = von;
   assign vga.pixel_x     = x;
   assign vga.pixel_y     = y;
   assign vga.line_start  = ls;
   assign vga.frame_start = fs;
   assign vga.state_dbg   = (state == RUN);
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: full-size VGA instance plus a small-geometry DIV=4 active-high instance.
// Expected outputs come from an arithmetic model of tick count since entering RUN.
module tb_vga_timing_ctrl;
   localparam int W = 26;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   vga_timing_if #(.CW(10)) if_a ();
   vga_timing_if #(.CW(10)) if_b ();

   vga_timing_ctrl #(.DIV(2)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (if_a.master)
   );

   vga_timing_ctrl #(
      .DIV(4), .H_VISIBLE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_VISIBLE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1), .CW(10)
   ) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (if_b.master)
   );

   logic [W-1:0] exp_qa[$];
   logic [W-1:0] exp_qb[$];
   logic [W-1:0] act_a, act_b;
   int  n_checks = 0;
   int  n_fail   = 0;
   int  c_a = 0, c_b = 0;
   bit  run_a = 0, run_b = 0;
   bit  done = 0;

   assign act_a = {if_a.pixel_tick, if_a.hsync, if_a.vsync, if_a.video_on,
                   if_a.line_start, if_a.frame_start, if_a.pixel_x, if_a.pixel_y};
   assign act_b = {if_b.pixel_tick, if_b.hsync, if_b.vsync, if_b.video_on,
                   if_b.line_start, if_b.frame_start, if_b.pixel_x, if_b.pixel_y};

   // c = clk edges since entering RUN; tick count t = c / div gives the scan position.
   function automatic logic [W-1:0] model(input int c, input bit run, input int div,
                                          input int hv, input int hfp, input int hs, input int hbp,
                                          input int vv, input int vfp, input int vs, input int vbp,
                                          input bit pol);
      int ht, vt, t, x, y;
      bit tk, ls, fs, hsy, vsy, von;
      if (!run) return {1'b0, ~pol, ~pol, 1'b0, 1'b0, 1'b0, 10'd0, 10'd0};
      ht  = hv + hfp + hs + hbp;
      vt  = vv + vfp + vs + vbp;
      t   = c / div;
      x   = t % ht;
      y   = (t / ht) % vt;
      tk  = (c % div) == div - 1;
      ls  = (c % div == 0) && (t > 0) && (x == 0);
      fs  = ls && (y == 0);
      hsy = (x >= hv + hfp && x < hv + hfp + hs) ? pol : ~pol;
      vsy = (y >= vv + vfp && y < vv + vfp + vs) ? pol : ~pol;
      von = (x < hv) && (y < vv);
      return {tk, hsy, vsy, von, ls, fs, 10'(x), 10'(y)};
   endfunction

   function automatic logic [W-1:0] exp_a_now();
      return model(c_a, run_a, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
   endfunction

   function automatic logic [W-1:0] exp_b_now();
      return model(c_b, run_b, 4, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1);
   endfunction

   task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got tick,hs,vs,von,ls,fs=%b x=%0d y=%0d, expected %b x=%0d y=%0d",
                  name, $time, got[25:20], got[19:10], got[9:0], exp[25:20], exp[19:10], exp[9:0]);
      end
   endtask

   // Reference model: pushes the expected post-edge outputs of both instances.
   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) run_a = 0;
         else if (if_a.en) begin c_a = run_a ? c_a + 1 : 0; run_a = 1; end
         else run_a = 0;
         if (!rst_n) run_b = 0;
         else if (if_b.en) begin c_b = run_b ? c_b + 1 : 0; run_b = 1; end
         else run_b = 0;
         exp_qa.push_back(exp_a_now());
         exp_qb.push_back(exp_b_now());
      end
   end

   // Monitor: compares DUT outputs away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_qa.size() > 0) check("scan_a", act_a, exp_qa.pop_front());
         if (exp_qb.size() > 0) check("scan_b", act_b, exp_qb.pop_front());
      end
   end

   // Instance B: mostly running, with rare random one-cycle en drops.
   initial begin
      if_b.en = 1'b0;
      @(posedge rst_n);
      forever begin
         @(negedge clk);
         #1;
         if (!done) if_b.en = ($urandom_range(0, 1499) != 0);
      end
   end

   initial begin
      bit reached;
      if_a.en = 1'b0;
      rst_n   = 1'b0;
      repeat (3) @(negedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      #1 if_a.en = 1'b1;

      // Run into the horizontal sync window, then reset asynchronously.
      reached = 0;
      for (int i = 0; i < 5000 && !reached; i++) begin
         @(negedge clk);
         reached = run_a && ((c_a / 2) % 800 == 700);
      end
      n_checks++;
      if (!reached) begin
         n_fail++;
         $display("FAIL reach_x700: model position x=%0d, required 700 within 5000 clks", (c_a / 2) % 800);
      end
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_a", act_a, model(0, 0, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
      check("async_rst_b", act_b, model(0, 0, 4, 8, 2, 3, 2, 4, 1, 2, 1, 1'b1));
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Two full lines uninterrupted, then random run lengths with short idle gaps.
      repeat (3300) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         #1 if_a.en = 1'b0;
         repeat ($urandom_range(1, 4)) @(negedge clk);
         #1 if_a.en = 1'b1;
         repeat ($urandom_range(800, 2400)) @(negedge clk);
      end

      done = 1;
      repeat (4) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
